mdio_responder: RTL and testbench

- PHY-side MDIO management slave: the far end of the MDIO bus driven by the team's MDIO controller.
- Decodes serial Clause-22 frames from MDC/MDIO_OUT/MDIO_OE: ST=01, OP 10=read / 01=write, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], all MSB first.
- Writes to, or reads from, a 32 x 16-bit register file through a simple parallel port.
- For reads, drives the data back on MDIO_IN.

---
 rtl/mdio_responder_if.sv | 26 ++
 rtl/mdio_responder.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_responder_if.sv
// MDIO bus bundle between the management controller (master) and the
// PHY-side responder (slave). MDC and the controller data/enable come from
// the master; MDIO_IN/MDIO_IN_OE are the responder's read-back path.
interface mdio_responder_if;
  logic MDC;
  logic MDIO_OUT;
  logic MDIO_OE;
  logic MDIO_IN;
  logic MDIO_IN_OE;

  modport master (
    output MDC,
    output MDIO_OUT,
    output MDIO_OE,
    input  MDIO_IN,
    input  MDIO_IN_OE
  );

  modport slave (
    input  MDC,
    input  MDIO_OUT,
    input  MDIO_OE,
    output MDIO_IN,
    output MDIO_IN_OE
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO management responder (PHY side).
// Decodes ST/OP/PHYAD/REGAD/TA/DATA from MDC/MDIO_OUT/MDIO_OE, writes a
// 32 x 16 register file through a parallel port and serialises reads back
// on MDIO_IN. MDC is synchronous to CLK; edges are found by comparing MDC
// with a one-CLK delayed copy.
//
// Optional feature macro: PHY_ADDR_MATCH_EN
//   defined   : frames whose PHYAD differs from PHY_ADDR are consumed silently
//   undefined : every well-formed frame is accepted regardless of PHYAD
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | waiting for the first ST bit (0 with MDIO_OE high)
// START      | expecting the second ST bit (1)
// OP_CODE    | shifting the 2 opcode bits
// PHY_ADDR_S | shifting PHYAD
// REG_ADDR_S | shifting REGAD; MEM_ADDR updated on the last bit
// TURNAROUND | 2 TA bits; a read takes the bus on the first MDC fall
// WRITE_DATA | shifting 16 write-data bits, strobe after the last one
// READ_DATA  | driving 16 read-data bits on MDC falls, then release
// CONSUME    | (PHY_ADDR_MATCH_EN only) counting out a frame for another PHY
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR   = 5'd1,
  parameter int         REG_RD_LAT = 0
) (
  input  logic            CLK,
  input  logic            RESET,
  mdio_responder_if.slave bus,
  input  logic [15:0]     MEM_RD_DATA,
  output logic [4:0]      MEM_ADDR,
  output logic [15:0]     MEM_WR_DATA,
  output logic            MEM_WR_EN,
  output logic            FRAME_ERR,
  output logic            BUSY
);

  // Read data is taken combinationally from MEM_ADDR; no other latency is
  // supported, and the PHY address must fit the 5-bit PHYAD field.
  if (REG_RD_LAT != 0 || $bits(PHY_ADDR) != 5) begin : g_param_chk
    $error("mdio_responder: REG_RD_LAT must be 0 and PHY_ADDR 5 bits wide");
  end

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START      = 4'd1,
    OP_CODE    = 4'd2,
    PHY_ADDR_S = 4'd3,
    REG_ADDR_S = 4'd4,
    TURNAROUND = 4'd5,
    WRITE_DATA = 4'd6,
    READ_DATA  = 4'd7
`ifdef PHY_ADDR_MATCH_EN
    ,
    CONSUME    = 4'd8
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        mdc_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        rd_q, rd_d;
  logic [4:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_wr_data_q, mem_wr_data_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic        frame_err_q, frame_err_d;
  logic        mdio_in_q, mdio_in_d;
  logic        mdio_in_oe_q, mdio_in_oe_d;

  logic        rise;
  logic        fall;
  logic [15:0] shift_in;
  logic        abortable;
  logic        abort;

  assign rise     = bus.MDC & ~mdc_q;
  assign fall     = ~bus.MDC & mdc_q;
  assign shift_in = {shift_q[14:0], bus.MDIO_OUT};

  // While the responder owns the bus (read TA/data) the controller's OE is
  // legitimately low, so only controller-driven phases can be aborted.
  assign abortable = (state_q == START) || (state_q == OP_CODE) ||
                     (state_q == PHY_ADDR_S) || (state_q == REG_ADDR_S) ||
                     (state_q == WRITE_DATA) ||
                     ((state_q == TURNAROUND) && !rd_q);
  assign abort     = rise && !bus.MDIO_OE && abortable;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      mdc_q         <= 1'b0;
      cnt_q         <= 5'd0;
      shift_q       <= 16'd0;
      rd_q          <= 1'b0;
      mem_addr_q    <= 5'd0;
      mem_wr_data_q <= 16'd0;
      mem_wr_en_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      mdio_in_q     <= 1'b0;
      mdio_in_oe_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mdc_q         <= bus.MDC;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      rd_q          <= rd_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      frame_err_q   <= frame_err_d;
      mdio_in_q     <= mdio_in_d;
      mdio_in_oe_q  <= mdio_in_oe_d;
    end
  end

  // Frame decode: next state, field counters, strobes and the MDIO_IN driver.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    rd_d          = rd_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_en_d   = 1'b0;
    frame_err_d   = 1'b0;
    mdio_in_d     = mdio_in_q;
    mdio_in_oe_d  = mdio_in_oe_q;

    if (abort) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise && bus.MDIO_OE && !bus.MDIO_OUT) begin
            state_d = START;
          end
        end

        START: begin
          if (rise) begin
            if (bus.MDIO_OUT) begin
              state_d = OP_CODE;
              cnt_d   = 5'd1;
            end else begin
              frame_err_d = 1'b1;
              state_d     = IDLE;
            end
          end
        end

        OP_CODE: begin
          if (rise) begin
            shift_d = shift_in;
            if (cnt_q == 5'd0) begin
              case (shift_in[1:0])
                2'b10: begin
                  rd_d    = 1'b1;
                  state_d = PHY_ADDR_S;
                  cnt_d   = 5'd4;
                end
                2'b01: begin
                  rd_d    = 1'b0;
                  state_d = PHY_ADDR_S;
                  cnt_d   = 5'd4;
                end
                default: begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
                end
              endcase
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end

        PHY_ADDR_S: begin
          if (rise) begin
            shift_d = shift_in;
            if (cnt_q == 5'd0) begin
`ifdef PHY_ADDR_MATCH_EN
              if (shift_in[4:0] != PHY_ADDR) begin
                // REGAD (5) + TA (2) + DATA (16) still to come.
                state_d = CONSUME;
                cnt_d   = 5'd22;
              end else begin
                state_d = REG_ADDR_S;
                cnt_d   = 5'd4;
              end
`else
              state_d = REG_ADDR_S;
              cnt_d   = 5'd4;
`endif
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end

        REG_ADDR_S: begin
          if (rise) begin
            shift_d = shift_in;
            if (cnt_q == 5'd0) begin
              mem_addr_d = shift_in[4:0];
              state_d    = TURNAROUND;
              cnt_d      = 5'd1;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end

        TURNAROUND: begin
          // MEM_ADDR settled on the last REGAD rise, so read data is valid
          // by the first fall; the TA bit driven here is 0.
          if (rd_q && fall && !mdio_in_oe_q) begin
            shift_d      = MEM_RD_DATA;
            mdio_in_oe_d = 1'b1;
            mdio_in_d    = 1'b0;
          end
          if (rise) begin
            if (cnt_q == 5'd0) begin
              state_d = rd_q ? READ_DATA : WRITE_DATA;
              cnt_d   = rd_q ? 5'd16 : 5'd15;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end

        WRITE_DATA: begin
          if (rise) begin
            shift_d = shift_in;
            if (cnt_q == 5'd0) begin
              mem_wr_en_d   = 1'b1;
              mem_wr_data_d = shift_in;
              state_d       = IDLE;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end

        READ_DATA: begin
          // 16 falls shift the word out; the 17th releases the bus.
          if (fall) begin
            if (cnt_q == 5'd0) begin
              mdio_in_oe_d = 1'b0;
              mdio_in_d    = 1'b0;
              state_d      = IDLE;
            end else begin
              mdio_in_d = shift_q[15];
              shift_d   = {shift_q[14:0], 1'b0};
              cnt_d     = cnt_q - 5'd1;
            end
          end
        end

`ifdef PHY_ADDR_MATCH_EN
        CONSUME: begin
          if (rise) begin
            if (cnt_q == 5'd0) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
        end
`endif

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign MEM_ADDR       = mem_addr_q;
  assign MEM_WR_DATA    = mem_wr_data_q;
  assign MEM_WR_EN      = mem_wr_en_q;
  assign FRAME_ERR      = frame_err_q;
  assign BUSY           = (state_q != IDLE);
  assign bus.MDIO_IN    = mdio_in_q;
  assign bus.MDIO_IN_OE = mdio_in_oe_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: the bench plays the MDIO controller,
// generating MDC from CLK (4 CLKs per MDC period) and sampling MDIO_IN
// just before each MDC rise. Register-file reads come from a fixed table.
module tb_mdio_responder;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] MEM_RD_DATA;
  logic [4:0]  MEM_ADDR;
  logic [15:0] MEM_WR_DATA;
  logic        MEM_WR_EN;
  logic        FRAME_ERR;
  logic        BUSY;

  mdio_responder_if bus();

  mdio_responder #(.PHY_ADDR(5'd1), .REG_RD_LAT(0)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus),
    .MEM_RD_DATA (MEM_RD_DATA),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WR_DATA (MEM_WR_DATA),
    .MEM_WR_EN   (MEM_WR_EN),
    .FRAME_ERR   (FRAME_ERR),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  assign MEM_RD_DATA = (MEM_ADDR == 5'd7) ? 16'h1234 : {11'd0, MEM_ADDR};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          err_cnt  = 0;
  logic [4:0]  wr_addr_log [64];
  logic [15:0] wr_data_log [64];

  // Count strobe cycles away from the active edge; a stretched pulse counts twice.
  always @(negedge CLK) begin
    if (MEM_WR_EN) begin
      wr_addr_log[wr_cnt[5:0]] <= MEM_ADDR;
      wr_data_log[wr_cnt[5:0]] <= MEM_WR_DATA;
      wr_cnt <= wr_cnt + 1;
    end
    if (FRAME_ERR) err_cnt <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One MDC period: fall, two CLKs low, rise, two CLKs high. MDIO_IN is
  // sampled just before the rise, as the controller would.
  task automatic mdio_bit(input logic oe, input logic d, output logic rd, output logic rd_oe);
    @(posedge CLK); #1;
    bus.MDC      = 1'b0;
    bus.MDIO_OE  = oe;
    bus.MDIO_OUT = d;
    repeat (2) @(posedge CLK);
    #1;
    rd    = bus.MDIO_IN;
    rd_oe = bus.MDIO_IN_OE;
    bus.MDC = 1'b1;
    @(posedge CLK);
  endtask

  task automatic idle_bits(input int n);
    logic rd, rdoe;
    for (int k = 0; k < n; k++) mdio_bit(1'b0, 1'b1, rd, rdoe);
  endtask

  task automatic settle();
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // Sends npre preamble ones then the first nbits bits of a 32-bit frame.
  task automatic send_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] wdata, input int npre, input int nbits,
                            output logic [15:0] rdata, output logic pre_oe,
                            output logic ta_oe, output logic ta_in, output logic ta2_in);
    logic [31:0] fr;
    logic        oe, rd, rdoe, is_rd;
    is_rd  = (op == 2'b10);
    fr     = {2'b01, op, phy, regad, 2'b10, wdata};
    rdata  = 16'd0;
    pre_oe = 1'b1;
    ta_oe  = 1'b0;
    ta_in  = 1'b1;
    ta2_in = 1'b1;
    for (int k = 0; k < npre; k++) mdio_bit(1'b1, 1'b1, rd, rdoe);
    for (int i = 31; i >= 32 - nbits; i--) begin
      oe = is_rd ? (i >= 18) : 1'b1;
      mdio_bit(oe, fr[i], rd, rdoe);
      if (i == 18) pre_oe = rdoe;
      if (i == 17) begin
        ta_oe = rdoe;
        ta_in = rd;
      end
      if (i == 16) ta2_in = rd;
      if (i <= 15) rdata[i] = rd;
    end
  endtask

  initial begin
    logic [15:0] rdata;
    logic        pre_oe, ta_oe, ta_in, ta2_in, rd, rdoe;
    int          wb, eb;

    bus.MDC      = 1'b0;
    bus.MDIO_OUT = 1'b1;
    bus.MDIO_OE  = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check_eq("rst_in_oe",  {31'd0, bus.MDIO_IN_OE}, 32'd0);
    check_eq("rst_in",     {31'd0, bus.MDIO_IN}, 32'd0);
    check_eq("rst_busy",   {31'd0, BUSY}, 32'd0);
    check_eq("rst_wr_en",  {31'd0, MEM_WR_EN}, 32'd0);
    check_eq("rst_addr",   {27'd0, MEM_ADDR}, 32'd0);
    check_eq("rst_wdata",  {16'd0, MEM_WR_DATA}, 32'd0);
    RESET = 1'b0;
    idle_bits(2);

    // Plain write.
    wb = wr_cnt; eb = err_cnt;
    send_frame(2'b01, 5'd1, 5'h03, 16'hA5C3, 2, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    settle();
    check_eq("wr_pulses",  wr_cnt - wb, 1);
    check_eq("wr_addr",    {27'd0, wr_addr_log[wb[5:0]]}, 32'h3);
    check_eq("wr_data",    {16'd0, wr_data_log[wb[5:0]]}, 32'hA5C3);
    check_eq("wr_hold",    {16'd0, MEM_WR_DATA}, 32'hA5C3);
    check_eq("wr_no_err",  err_cnt - eb, 0);
    check_eq("wr_busy",    {31'd0, BUSY}, 32'd0);

    // Read of REG 7 (table returns 16'h1234).
    wb = wr_cnt; eb = err_cnt;
    send_frame(2'b10, 5'd1, 5'h07, 16'h0000, 2, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    check_eq("rd_pre_oe",  {31'd0, pre_oe}, 32'd0);
    check_eq("rd_ta_oe",   {31'd0, ta_oe}, 32'd1);
    check_eq("rd_ta_bit",  {31'd0, ta_in}, 32'd0);
    check_eq("rd_ta2_bit", {31'd0, ta2_in}, 32'd0);
    check_eq("rd_data",    {16'd0, rdata}, 32'h1234);
    check_eq("rd_addr",    {27'd0, MEM_ADDR}, 32'h7);
    mdio_bit(1'b0, 1'b1, rd, rdoe);
    check_eq("rd_release", {31'd0, rdoe}, 32'd0);
    settle();
    check_eq("rd_busy",    {31'd0, BUSY}, 32'd0);
    check_eq("rd_no_wr",   wr_cnt - wb, 0);
    check_eq("rd_no_err",  err_cnt - eb, 0);

    // Illegal opcode 11, then a valid write.
    wb = wr_cnt; eb = err_cnt;
    send_frame(2'b11, 5'd1, 5'h04, 16'h0000, 1, 4, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    settle();
    check_eq("op11_err",   err_cnt - eb, 1);
    check_eq("op11_busy",  {31'd0, BUSY}, 32'd0);
    idle_bits(1);
    send_frame(2'b01, 5'd1, 5'h04, 16'h0F0F, 1, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    settle();
    check_eq("op11_no_wr_then_one", wr_cnt - wb, 1);
    check_eq("op11_next_addr", {27'd0, wr_addr_log[wb[5:0]]}, 32'h4);
    check_eq("op11_next_data", {16'd0, wr_data_log[wb[5:0]]}, 32'h0F0F);

    // MDIO_OE dropped after 8 write-data bits.
    wb = wr_cnt; eb = err_cnt;
    send_frame(2'b01, 5'd1, 5'h05, 16'hBEEF, 1, 24, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    mdio_bit(1'b0, 1'b0, rd, rdoe);
    settle();
    check_eq("abort_err",  err_cnt - eb, 1);
    check_eq("abort_no_wr", wr_cnt - wb, 0);
    check_eq("abort_busy", {31'd0, BUSY}, 32'd0);
    check_eq("abort_wdata_held", {16'd0, MEM_WR_DATA}, 32'h0F0F);
    idle_bits(2);

    // RESET in the middle of read data.
    send_frame(2'b10, 5'd1, 5'h07, 16'h0000, 1, 21, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    #1;
    check_eq("rstmid_oe_before", {31'd0, bus.MDIO_IN_OE}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    check_eq("rstmid_oe_after", {31'd0, bus.MDIO_IN_OE}, 32'd0);
    check_eq("rstmid_busy",     {31'd0, BUSY}, 32'd0);
    RESET = 1'b0;
    idle_bits(2);

    // Two back-to-back writes.
    wb = wr_cnt; eb = err_cnt;
    send_frame(2'b01, 5'd1, 5'h01, 16'h1111, 1, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    send_frame(2'b01, 5'd1, 5'h02, 16'h2222, 0, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    settle();
    check_eq("b2b_pulses", wr_cnt - wb, 2);
    check_eq("b2b_addr0",  {27'd0, wr_addr_log[wb[5:0]]}, 32'h1);
    check_eq("b2b_data0",  {16'd0, wr_data_log[wb[5:0]]}, 32'h1111);
    check_eq("b2b_addr1",  {27'd0, wr_addr_log[wb[5:0] + 6'd1]}, 32'h2);
    check_eq("b2b_data1",  {16'd0, wr_data_log[wb[5:0] + 6'd1]}, 32'h2222);
    check_eq("b2b_no_err", err_cnt - eb, 0);

`ifdef PHY_ADDR_MATCH_EN
    // Frames for PHY 2 are consumed silently.
    wb = wr_cnt; eb = err_cnt;
    send_frame(2'b01, 5'd2, 5'h09, 16'h5A5A, 1, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    settle();
    check_eq("phy2_no_wr",  wr_cnt - wb, 0);
    check_eq("phy2_no_err", err_cnt - eb, 0);
    check_eq("phy2_busy",   {31'd0, BUSY}, 32'd0);
    send_frame(2'b10, 5'd2, 5'h07, 16'h0000, 1, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    check_eq("phy2_rd_oe",  {31'd0, ta_oe}, 32'd0);
    idle_bits(1);
    settle();
    check_eq("phy2_rd_busy", {31'd0, BUSY}, 32'd0);
    wb = wr_cnt; eb = err_cnt;
    send_frame(2'b01, 5'd1, 5'h00, 16'hFFFF, 1, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    settle();
    check_eq("phy1_pulses", wr_cnt - wb, 1);
    check_eq("phy1_addr",   {27'd0, wr_addr_log[wb[5:0]]}, 32'h0);
    check_eq("phy1_data",   {16'd0, wr_data_log[wb[5:0]]}, 32'hFFFF);
    check_eq("phy1_no_err", err_cnt - eb, 0);
`else
    // Without address matching any PHYAD is accepted.
    wb = wr_cnt; eb = err_cnt;
    send_frame(2'b01, 5'd2, 5'h09, 16'h5A5A, 1, 32, rdata, pre_oe, ta_oe, ta_in, ta2_in);
    settle();
    check_eq("anyphy_pulses", wr_cnt - wb, 1);
    check_eq("anyphy_addr",   {27'd0, wr_addr_log[wb[5:0]]}, 32'h9);
    check_eq("anyphy_data",   {16'd0, wr_data_log[wb[5:0]]}, 32'h5A5A);
    check_eq("anyphy_no_err", err_cnt - eb, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
